async_fifo: RTL and testbench



---
 rtl/async_fifo_pkg.sv | 9 +
 rtl/async_fifo_mem.sv | 33 +++
 rtl/async_fifo.sv | 85 ++++++++
 tb/tb_async_fifo.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/async_fifo_pkg.sv
// Shared widths and types for the single-clock byte FIFO.
package async_fifo_pkg;
    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 3;
    localparam int DEPTH_DEF  = 1 << ADDR_W_DEF;

    typedef logic [ADDR_W_DEF:0]   ptr_t;
    typedef logic [DATA_W_DEF-1:0] data_t;
endpackage

// File: rtl/async_fifo_mem.sv
// DEPTH x DATA_W register array: one synchronous write port, one registered read port.
module fifo_mem
    import async_fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Storage is deliberately left out of reset; only the output register clears.
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst)     rdata_q <= '0;
        else if (re) rdata_q <= mem_q[raddr];
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/async_fifo.sv
// Single-clock 8-entry byte FIFO with registered read data and full/empty flags.
// Define ASYNC_FIFO_STATUS_EN to add level/overflow/underflow status outputs.
module async_fifo
    import async_fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              w_en,
    input  logic [DATA_W-1:0] w_data,
    input  logic              r_en,
    output logic [DATA_W-1:0] r_data,
    output logic              empty,
    output logic              full
`ifdef ASYNC_FIFO_STATUS_EN
    ,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    output logic              underflow
`endif
);
    logic [ADDR_W:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic            empty_q, empty_d, full_q, full_d;
    logic            wr_acc, rd_acc;

    // Acceptance looks at the flags as they stand before this edge.
    assign wr_acc = w_en & ~full_q  & ~rst;
    assign rd_acc = r_en & ~empty_q & ~rst;

    always_comb begin
        wptr_d  = wptr_q + {{ADDR_W{1'b0}}, wr_acc};
        rptr_d  = rptr_q + {{ADDR_W{1'b0}}, rd_acc};
        empty_d = (wptr_d == rptr_d);
        full_d  = (wptr_d[ADDR_W-1:0] == rptr_d[ADDR_W-1:0]) &&
                  (wptr_d[ADDR_W] != rptr_d[ADDR_W]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            empty_q <= empty_d;
            full_q  <= full_d;
        end
    end

    fifo_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_acc),
        .waddr (wptr_q[ADDR_W-1:0]),
        .wdata (w_data),
        .re    (rd_acc),
        .raddr (rptr_q[ADDR_W-1:0]),
        .rdata (r_data)
    );

    assign empty = empty_q;
    assign full  = full_q;

`ifdef ASYNC_FIFO_STATUS_EN
    logic ovf_q, udf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (w_en && full_q)  ovf_q <= 1'b1;
            if (r_en && empty_q) udf_q <= 1'b1;
        end
    end

    assign level     = wptr_q - rptr_q;
    assign overflow  = ovf_q;
    assign underflow = udf_q;
`endif
endmodule

// File: tb/tb_async_fifo.sv
// Directed test of async_fifo: fill/drain, full/empty corners, wrap, reset flush.
module tb_async_fifo;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       w_en = 1'b0;
    logic [7:0] w_data = 8'h00;
    logic       r_en = 1'b0;
    logic [7:0] r_data;
    logic       empty, full;
`ifdef ASYNC_FIFO_STATUS_EN
    logic [3:0] level;
    logic       overflow, underflow;
`endif

    int compared   = 0;
    int mismatched = 0;
    int wcnt       = 0;

    always #5 clk = ~clk;

    async_fifo dut (
        .clk    (clk),
        .rst    (rst),
        .w_en   (w_en),
        .w_data (w_data),
        .r_en   (r_en),
        .r_data (r_data),
        .empty  (empty),
        .full   (full)
`ifdef ASYNC_FIFO_STATUS_EN
        ,
        .level     (level),
        .overflow  (overflow),
        .underflow (underflow)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive at the falling edge, let one rising edge pass, return at the next falling edge.
    task automatic cyc(input logic we, input logic [7:0] wd, input logic re);
        w_en = we; w_data = wd; r_en = re;
        @(posedge clk);
        @(negedge clk);
        w_en = 1'b0; r_en = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        rst = 1'b1;
        cyc(0, 8'h00, 0);
        cyc(0, 8'h00, 0);
        rst = 1'b0;
        cyc(0, 8'h00, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_rdata", r_data, 8'h00);

        // Write 0..6, then 8 reads; the last one finds the FIFO empty.
        for (int i = 0; i < 7; i++) begin
            cyc(1, 8'(i), 0);
            wcnt++;
        end
        chk("t2_empty_after_wr", empty, 0);
        for (int i = 0; i < 7; i++) begin
            cyc(0, 8'h00, 1);
            chk($sformatf("t2_rd%0d", i), r_data, 32'(i));
        end
        chk("t2_empty_after7", empty, 1);
        cyc(0, 8'h00, 1);
        chk("t2_rd8_hold", r_data, 8'h06);
        chk("t2_empty_after8", empty, 1);

        // Fill to full, drop a 9th write, drain all.
        for (int i = 0; i < 8; i++) begin
            cyc(1, 8'h10 + 8'(i), 0);
            wcnt++;
            if (i == 6) chk("t3_notfull7", full, 0);
        end
        chk("t3_full", full, 1);
        cyc(1, 8'hFF, 0);
        chk("t3_full_after_drop", full, 1);
        chk("t3_rdata_hold", r_data, 8'h06);
        for (int i = 0; i < 8; i++) begin
            cyc(0, 8'h00, 1);
            chk($sformatf("t3_rd%0d", i), r_data, 32'h10 + 32'(i));
        end
        chk("t3_empty", empty, 1);

        // Three words preloaded, then 20 cycles of simultaneous read+write.
        for (int i = 0; i < 3; i++) begin
            cyc(1, 8'h20 + 8'(i), 0);
            wcnt++;
        end
        for (int i = 0; i < 20; i++) begin
            cyc(1, 8'h23 + 8'(i), 1);
            wcnt++;
            chk($sformatf("t4_rd%0d", i), r_data, 32'h20 + 32'(i));
            chk($sformatf("t4_flags%0d", i), {full, empty}, 2'b00);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(0, 8'h00, 1);
            chk($sformatf("t4_drain%0d", i), r_data, 32'h34 + 32'(i));
        end
        chk("t4_empty", empty, 1);

        // Wrap-around: fill 8 / drain 8 three times; write pointer MSB tracks passes.
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 8; i++) begin
                cyc(1, 8'h40 + 8'(p * 8 + i), 0);
                wcnt++;
            end
            chk($sformatf("t5_full_p%0d", p), full, 1);
            chk($sformatf("t5_msb_p%0d", p), dut.wptr_q[3], 32'((wcnt >> 3) & 1));
            for (int i = 0; i < 8; i++) begin
                cyc(0, 8'h00, 1);
                chk($sformatf("t5_rd_p%0d_%0d", p, i), r_data, 32'h40 + 32'(p * 8 + i));
            end
            chk($sformatf("t5_empty_p%0d", p), empty, 1);
        end

        // Read+write while empty: write wins, read ignored, r_data holds.
        cyc(1, 8'h55, 1);
        chk("t6_rw_empty_notempty", empty, 0);
        chk("t6_rw_empty_hold", r_data, 8'h57);
        cyc(0, 8'h00, 1);
        chk("t6_rd55", r_data, 8'h55);
        chk("t6_empty", empty, 1);

        // Read+write while full: read wins, write dropped.
        for (int i = 0; i < 8; i++) cyc(1, 8'h60 + 8'(i), 0);
        chk("t7_full", full, 1);
        cyc(1, 8'hEE, 1);
        chk("t7_rw_full_rd", r_data, 8'h60);
        chk("t7_rw_full_notfull", full, 0);
        for (int i = 1; i < 8; i++) begin
            cyc(0, 8'h00, 1);
            chk($sformatf("t7_rd%0d", i), r_data, 32'h60 + 32'(i));
        end
        chk("t7_empty", empty, 1);

        // Reset with 5 stored words and pending requests flushes everything.
        for (int i = 0; i < 5; i++) cyc(1, 8'h80 + 8'(i), 0);
        chk("t8_notempty", empty, 0);
        rst = 1'b1;
        cyc(1, 8'h99, 1);
        rst = 1'b0;
        chk("t8_rst_empty", empty, 1);
        chk("t8_rst_full", full, 0);
        chk("t8_rst_rdata", r_data, 8'h00);
        cyc(0, 8'h00, 1);
        chk("t8_rd_ignored", r_data, 8'h00);
        chk("t8_still_empty", empty, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
